// File: rtl/scm_1r1w_port_arbiter_if.sv
// Requester-side bundle for the shared 1R1W SCM port arbiter.
// Per-port fields are packed back to back, port 0 in the least-significant slot.
interface scm_1r1w_port_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
);
  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS*NUM_BYTE-1:0]   be_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]           rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/scm_1r1w_port_arbiter.sv
// Shares one latch-based 1R1W SCM among several requesters with independent
// round-robin read/write arbitration, read-after-write hazard blocking and anti-starvation.
module scm_1r1w_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  scm_1r1w_port_arbiter_if.slave bus,
  output logic                  scm_re_o,
  output logic [ADDR_WIDTH-1:0] scm_raddr_o,
  input  logic [DATA_WIDTH-1:0] scm_rdata_i,
  output logic                  scm_we_o,
  output logic [ADDR_WIDTH-1:0] scm_waddr_o,
  output logic [DATA_WIDTH-1:0] scm_wdata_o,
  output logic [NUM_BYTE-1:0]   scm_be_o
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (32'(p) == NUM_PORTS - 1) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input ptr_t i);
    return NUM_PORTS'(1) << i;
  endfunction

  // First set bit of cand scanning upward from ptr with wrap-around.
  function automatic void rr_pick(input logic [NUM_PORTS-1:0] cand, input ptr_t ptr,
                                  output logic found, output ptr_t win);
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && cand[ptr_t'(idx)]) begin
        found = 1'b1;
        win   = ptr_t'(idx);
      end
    end
  endfunction

  ptr_t                  rd_ptr, wr_ptr;
  logic [NUM_PORTS-1:0]  rvalid_q;
  logic                  prev_wvalid;
  logic [ADDR_WIDTH-1:0] prev_waddr;
  logic                  starve_valid;
  logic [ADDR_WIDTH-1:0] starve_addr;
  logic [NUM_PORTS-1:0]  pend_q;

  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  wr_cand, rd_req, rd_haz, rd_cand, gnt;
  logic                  wr_found, rd_found, top_found, top_blocked, wr_haz;
  ptr_t                  wr_win, rd_win, top_win;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTE-1:0]   wr_be;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_addr[p] = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Write side first: its grant feeds the same-cycle read hazard check.
  always_comb begin
    wr_cand = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      wr_cand[p] = bus.req_i[p] & bus.we_i[p] &
                   ~(starve_valid && (port_addr[p] == starve_addr));
    end
    rr_pick(wr_cand, wr_ptr, wr_found, wr_win);
    if (rst) wr_found = 1'b0;
    wr_addr = port_addr[wr_win];
    wr_data = bus.wdata_i[32'(wr_win)*DATA_WIDTH +: DATA_WIDTH];
    wr_be   = bus.be_i[32'(wr_win)*NUM_BYTE +: NUM_BYTE];
    // A write with no byte lanes never opens a latch, so it cannot create a hazard.
    wr_haz  = wr_found && (wr_be != '0);
  end

  always_comb begin
    rd_req = '0;
    rd_haz = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rd_req[p] = bus.req_i[p] & ~bus.we_i[p];
      rd_haz[p] = (wr_haz && (port_addr[p] == wr_addr)) ||
                  (prev_wvalid && (port_addr[p] == prev_waddr));
    end
    rd_cand = rd_req & ~rd_haz;
    rr_pick(rd_req, rd_ptr, top_found, top_win);
    rr_pick(rd_cand, rd_ptr, rd_found, rd_win);
    top_blocked = top_found && rd_haz[top_win];
    if (rst) begin
      rd_found    = 1'b0;
      top_blocked = 1'b0;
    end
    rd_addr = port_addr[rd_win];
  end

  always_comb begin
    gnt = '0;
    if (wr_found) gnt = gnt | onehot(wr_win);
    if (rd_found) gnt = gnt | onehot(rd_win);
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = scm_rdata_i;
  assign scm_we_o     = wr_found;
  assign scm_waddr_o  = wr_addr;
  assign scm_wdata_o  = wr_data;
  assign scm_be_o     = wr_be;
  assign scm_re_o     = rd_found;
  assign scm_raddr_o  = rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      rvalid_q     <= '0;
      prev_wvalid  <= 1'b0;
      prev_waddr   <= '0;
      starve_valid <= 1'b0;
      starve_addr  <= '0;
      pend_q       <= '0;
    end else begin
      if (wr_found) wr_ptr <= ptr_inc(wr_win);
      if (rd_found) rd_ptr <= ptr_inc(rd_win);
      rvalid_q    <= rd_found ? onehot(rd_win) : '0;
      prev_wvalid <= wr_haz;
      prev_waddr  <= wr_addr;
      // Blocked head-of-line read masks writes to its address next cycle.
      if (top_blocked) begin
        starve_valid <= 1'b1;
        starve_addr  <= port_addr[top_win];
      end else if (starve_valid && rd_found && (rd_addr == starve_addr)) begin
        starve_valid <= 1'b0;
      end
      pend_q <= bus.req_i & ~gnt;
    end
  end

  a_req_held_until_gnt: assert property (
    @(posedge clk) disable iff (rst) ((pend_q & ~bus.req_i) == '0)
  );

endmodule

// File: tb/tb_scm_1r1w_port_arbiter.sv
// Scoreboard bench for scm_1r1w_port_arbiter: directed stimulus pushes expected
// grant/rvalid events, a negedge monitor pops and compares them.
module tb_scm_1r1w_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          scm_re, scm_we;
  logic [AW-1:0] scm_raddr, scm_waddr;
  logic [DW-1:0] scm_wdata, scm_rdata;
  logic [NB-1:0] scm_be;

  scm_1r1w_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) bus ();

  scm_1r1w_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .scm_re_o(scm_re), .scm_raddr_o(scm_raddr), .scm_rdata_i(scm_rdata),
    .scm_we_o(scm_we), .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata), .scm_be_o(scm_be)
  );

  // Behavioural SCM: registered read, byte-masked write on the rising edge.
  logic [DW-1:0] mem [32];
  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction
  initial for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
  always @(posedge clk) begin
    if (scm_re) scm_rdata <= mem[scm_raddr];
    if (scm_we)
      for (int b = 0; b < NB; b++)
        if (scm_be[b]) mem[scm_waddr][8*b +: 8] <= scm_wdata[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [3:0] rv;
    logic       we;
    logic       re;
    logic [4:0] raddr;
    logic [4:0] waddr;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  int   quiet_q[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  logic [NP-1:0] p_req = '0, p_we = '0, p_cont = '0, gnt_seen = '0;
  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];
  logic [NB-1:0] p_be    [NP];

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.req_i[p]              = p_req[p];
      bus.we_i[p]               = p_we[p];
      bus.addr_i[p*AW +: AW]    = p_addr[p];
      bus.wdata_i[p*DW +: DW]   = p_wdata[p];
      bus.be_i[p*NB +: NB]      = p_be[p];
    end
  endtask

  // Advance one cycle; granted one-shot requests drop, continuous writers bump data.
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (p_req[p] && gnt_seen[p]) begin
        if (p_cont[p]) begin
          if (p_we[p]) p_wdata[p] = p_wdata[p] + 32'd1;
        end else begin
          p_req[p] = 1'b0;
        end
      end
    end
    drive();
  endtask

  task automatic set_op(input int p, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic cont);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d; p_be[p] = be; p_cont[p] = cont;
  endtask

  task automatic push(input int c, input logic [3:0] g, input logic [3:0] rv, input logic we,
                      input logic re, input logic [4:0] ra, input logic [4:0] wa, input logic [31:0] rd);
    exp_t e;
    e.cyc = c; e.gnt = g; e.rv = rv; e.we = we; e.re = re; e.raddr = ra; e.waddr = wa; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle with visible output consumes one scoreboard entry.
  always @(negedge clk) begin
    gnt_seen = bus.gnt_o;
    if (quiet_q.size() > 0 && quiet_q[0] == cyc) begin
      void'(quiet_q.pop_front());
      chk("quiet_gnt", 32'(bus.gnt_o), 32'd0);
      chk("quiet_rvalid", 32'(bus.rvalid_o), 32'd0);
      chk("quiet_scm_we", 32'(scm_we), 32'd0);
      chk("quiet_scm_re", 32'(scm_re), 32'd0);
    end
    if ((bus.gnt_o | bus.rvalid_o) != '0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output cyc=%0d gnt=%b rvalid=%b", cyc, bus.gnt_o, bus.rvalid_o);
      end else begin
        mon_e = sb.pop_front();
        chk("cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("gnt", 32'(bus.gnt_o), 32'(mon_e.gnt));
        chk("rvalid", 32'(bus.rvalid_o), 32'(mon_e.rv));
        chk("scm_we", 32'(scm_we), 32'(mon_e.we));
        chk("scm_re", 32'(scm_re), 32'(mon_e.re));
        if (mon_e.re) chk("scm_raddr", 32'(scm_raddr), 32'(mon_e.raddr));
        if (mon_e.we) chk("scm_waddr", 32'(scm_waddr), 32'(mon_e.waddr));
        if (mon_e.rv != '0) chk("rdata", bus.rdata_o, mon_e.rdata);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_output expected at cyc=%0d gnt=%b rvalid=%b", mon_e.cyc, mon_e.gnt, mon_e.rv);
      end
      while (quiet_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL missed_quiet_check cyc=%0d", quiet_q.pop_front());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    for (int p = 0; p < NP; p++) begin
      p_addr[p] = '0; p_wdata[p] = '0; p_be[p] = '0;
    end
    rst = 1'b1;
    set_op(0, 1'b1, 5'd1, 32'h1, 4'hF, 1'b0);
    set_op(1, 1'b0, 5'd2, 32'h0, 4'h0, 1'b0);
    drive();

    // Reset with live requests: nothing granted, nothing reaches the macro.
    step();
    quiet_q.push_back(cyc);
    quiet_q.push_back(cyc + 1);
    step();
    rst = 1'b0;
    p_req = '0;
    drive();
    repeat (2) step();

    // Round-robin over four continuous readers.
    for (int p = 0; p < NP; p++) set_op(p, 1'b0, 5'(10 + p), 32'h0, 4'h0, 1'b1);
    drive();
    b = cyc;
    for (int k = 0; k < 8; k++)
      push(b + k, 4'b0001 << (k % 4), (k == 0) ? 4'b0000 : 4'b0001 << ((k - 1) % 4),
           1'b0, 1'b1, 5'(10 + k % 4), 5'd0, (k == 0) ? 32'h0 : init_val(10 + (k - 1) % 4));
    push(b + 8, 4'b0000, 4'b1000, 1'b0, 1'b0, 5'd0, 5'd0, init_val(13));
    repeat (4) step();
    p_cont = '0;
    repeat (6) step();

    // Write then read-after-write on the same address.
    set_op(0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0);
    drive();
    b = cyc;
    push(b, 4'b0001, 4'b0000, 1'b1, 1'b0, 5'd0, 5'd3, 32'h0);
    step();
    set_op(0, 1'b0, 5'd3, 32'h0, 4'h0, 1'b0);
    drive();
    push(b + 2, 4'b0001, 4'b0000, 1'b0, 1'b1, 5'd3, 5'd0, 32'h0);
    push(b + 3, 4'b0000, 4'b0001, 1'b0, 1'b0, 5'd0, 5'd0, 32'hDEADBEEF);
    repeat (5) step();

    // Concurrent read and write on different ports.
    set_op(1, 1'b1, 5'd5, 32'h5555_0005, 4'hF, 1'b0);
    set_op(2, 1'b0, 5'd9, 32'h0, 4'h0, 1'b0);
    drive();
    b = cyc;
    push(b, 4'b0110, 4'b0000, 1'b1, 1'b1, 5'd9, 5'd5, 32'h0);
    push(b + 1, 4'b0000, 4'b0100, 1'b0, 1'b0, 5'd0, 5'd0, init_val(9));
    repeat (3) step();

    // Partial byte-enable merge, read stalls behind two back-to-back writes.
    set_op(0, 1'b1, 5'd6, 32'hAAAAAAAA, 4'hF, 1'b0);
    drive();
    b = cyc;
    push(b, 4'b0001, 4'b0000, 1'b1, 1'b0, 5'd0, 5'd6, 32'h0);
    step();
    set_op(0, 1'b1, 5'd6, 32'h11223344, 4'b0101, 1'b0);
    set_op(1, 1'b0, 5'd6, 32'h0, 4'h0, 1'b0);
    drive();
    push(b + 1, 4'b0001, 4'b0000, 1'b1, 1'b0, 5'd0, 5'd6, 32'h0);
    push(b + 3, 4'b0010, 4'b0000, 1'b0, 1'b1, 5'd6, 5'd0, 32'h0);
    push(b + 4, 4'b0000, 4'b0010, 1'b0, 1'b0, 5'd0, 5'd0, 32'hAA22AA44);
    repeat (6) step();

    // Zero-byte-enable write does not block a same-cycle read of its address.
    set_op(2, 1'b1, 5'd7, 32'hFFFFFFFF, 4'h0, 1'b0);
    set_op(3, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0);
    drive();
    b = cyc;
    push(b, 4'b1100, 4'b0000, 1'b1, 1'b1, 5'd7, 5'd7, 32'h0);
    push(b + 1, 4'b0000, 4'b1000, 1'b0, 1'b0, 5'd0, 5'd0, init_val(7));
    repeat (3) step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    drive();
    step();

    // Starvation: continuous writer versus a reader of the same address.
    set_op(0, 1'b1, 5'd4, 32'h1000, 4'hF, 1'b1);
    set_op(1, 1'b0, 5'd4, 32'h0, 4'h0, 1'b0);
    drive();
    b = cyc;
    push(b, 4'b0001, 4'b0000, 1'b1, 1'b0, 5'd0, 5'd4, 32'h0);
    push(b + 2, 4'b0010, 4'b0000, 1'b0, 1'b1, 5'd4, 5'd0, 32'h0);
    push(b + 3, 4'b0001, 4'b0010, 1'b1, 1'b0, 5'd0, 5'd4, 32'h1000);
    repeat (3) step();
    p_cont = '0;
    repeat (3) step();

    // Reset while a read is requested; pointers (now rd=2, wr=1) must return to 0.
    set_op(3, 1'b0, 5'd13, 32'h0, 4'h0, 1'b0);
    rst = 1'b1;
    drive();
    quiet_q.push_back(cyc);
    quiet_q.push_back(cyc + 1);
    step();
    rst = 1'b0;
    p_req[3] = 1'b0;
    drive();
    step();
    set_op(0, 1'b1, 5'd21, 32'h2100, 4'hF, 1'b0);
    set_op(2, 1'b1, 5'd22, 32'h2200, 4'hF, 1'b0);
    set_op(1, 1'b0, 5'd14, 32'h0, 4'h0, 1'b0);
    set_op(3, 1'b0, 5'd15, 32'h0, 4'h0, 1'b0);
    drive();
    b = cyc;
    push(b, 4'b0011, 4'b0000, 1'b1, 1'b1, 5'd14, 5'd21, 32'h0);
    push(b + 1, 4'b1100, 4'b0010, 1'b1, 1'b1, 5'd15, 5'd22, init_val(14));
    push(b + 2, 4'b0000, 4'b1000, 1'b0, 1'b0, 5'd0, 5'd0, init_val(15));
    repeat (5) step();

    done = 1'b1;
  end
endmodule
